seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//   Receive side of the bcd_to_7seg path. Samples a multiplexed 7-segment display bus
//   (a..g segment lines plus one-hot digit enables), qualifies each digit pattern for stability,
//   and decodes it back to BCD. A complete multi-digit frame is presented on a valid/ready output.
//   Used as a display loopback checker and as a front end for sniffing external segment drivers.
// PARAMETERS
//   NUM_DIGITS      4  number of multiplexed digits; width of an_in
//   STABLE_CYCLES   4  consecutive identical samples needed to accept a digit (>=1)
//   SEG_ACTIVE_LOW  0  1 = seg_in/an_in are active-low and are inverted at the input register
// PORTS
//   clk        in   1             rising-edge clock
//   rst        in   1             synchronous reset, active-high
//   seg_in     in   7             segments; bit0=a, bit1=b, ... bit6=g
//   an_in      in   NUM_DIGITS    digit enable; one-hot when valid; bit i = digit i
//   out_ready  in   1             consumer accepts the frame when out_valid & out_ready
//   bcd_out    out  4*NUM_DIGITS  digit i at [4i+3:4i]
//   digit_err  out  NUM_DIGITS    bit i set = digit i held an illegal pattern
//   out_valid  out  1             frame held until it is accepted
//   overflow   out  1             sticky; a frame was dropped while out_valid=1
// BEHAVIOUR
//   Reset: all outputs 0, capture mask cleared, counters 0, shadow digits 0, inputs de-registered.
//   Inputs pass through one register stage (after optional inversion) before any logic.
//   Decode table (g..a): 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5,
//     1111101=6, 0000111=7, 1111111=8, 1101111=9, 0000000=blank->4'hF with err=0.
//     Any other pattern -> 4'hE with err=1.
//   Stability: the stable counter counts while the registered {seg,an} equals the previous sample
//     and an is one-hot. A change or a non-one-hot an (zero or multi-hot) reloads the count to 1
//     (0 if an is not one-hot). The digit is accepted on the cycle the count reaches STABLE_CYCLES.
//     Acceptance happens once per stable run; the counter saturates until the next change.
//   Accept: write the decoded value and err into shadow slot i, and set mask bit i. If the digit
//     is recaptured before the frame completes, the shadow slot is overwritten with the latest value.
//   Frame complete: all mask bits are set. On the next cycle the shadows copy to bcd_out/digit_err,
//     out_valid goes to 1, and the mask clears. When the last digit is captured in the same cycle,
//     that digit counts toward the completing frame.
//   Handshake: bcd_out and digit_err are stable while out_valid=1. out_valid drops the cycle after
//     out_valid & out_ready. When out_valid & out_ready coincides with a new frame complete, the new
//     frame loads and out_valid stays 1, with no drop and no overflow.
//   Frame complete while out_valid=1 and out_ready=0: the new frame is discarded, the mask still
//     clears, and overflow is set. overflow stays set until rst.
//   Latency: input-change->accept = 1 (input reg) + STABLE_CYCLES; last accept->out_valid = 1 cycle.
//   rst mid-frame discards partial captures and any pending output.
//   FSM: IDLE (mask=0) -> COLLECT (first accept) -> PUBLISH (mask full, 1 cycle) -> IDLE.
// STRUCTURE
//   Shared package/header: the seg7 pattern constants SEG_0..SEG_9, SEG_BLANK, plus BCD_BLANK=4'hF
//     and BCD_ERR=4'hE. These are the same constants bcd_to_7seg uses, so the encoder and decoder
//     stay consistent.
//   Sub-module seg7_to_bcd: purely combinational 7->{4,err} lookup, reusable standalone.
//   Top level contains the input register, stability counter, capture mask/shadows, FSM and the
//     output handshake.
// TESTING
//   1 Scan digits 3,2,1,0 = "1234" (an=1000 seg=0000110 ... an=0001 seg=1100110), 8 cycles each,
//     out_ready=1 -> out_valid pulses with bcd_out=16'h1234 and digit_err=0.
//   2 Hold one pattern for only STABLE_CYCLES-1 cycles per digit -> no accept, out_valid stays 0.
//     Extend the hold to STABLE_CYCLES -> accept occurs exactly 1+STABLE_CYCLES cycles after the
//     input changes.
//   3 Digit 1 = 1010101 and digit 2 = 0000000 -> nibble1=4'hE, nibble2=4'hF, digit_err=4'b0010.
//   4 an=0000 or 0110 for 20 cycles -> no accept and no counter advance. Then one-hot an resumes
//     and the frame completes normally.
//   5 out_ready=0 with a second frame "5678" completing -> bcd_out stays 16'h1234 and overflow=1.
//     Raise out_ready -> 1234 consumed, out_valid=0, overflow stays 1.
//   6 Assert rst after 2 digits are captured, then scan a full "9876" -> only 16'h9876 is output,
//     and every output reads 0 during rst.

Source files
------------

// File: rtl/seg7_scan_decoder_pkg.sv
// rtl/seg7_scan_decoder_pkg.sv - shared 7-segment pattern constants and FSM state type
package seg7_scan_decoder_pkg;

    // Segment patterns, bit6..bit0 = g..a, shared with the bcd_to_7seg encoder
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational 7-segment pattern to BCD lookup with illegal-pattern flag
module seg7_to_bcd
    import seg7_scan_decoder_pkg::*;
(
    input  logic [6:0] seg_in,
    output logic [3:0] bcd_out,
    output logic       err_out
);

    always_comb begin
        bcd_out = BCD_ERR;
        err_out = 1'b0;
        case (seg_in)
            SEG_0:     bcd_out = 4'd0;
            SEG_1:     bcd_out = 4'd1;
            SEG_2:     bcd_out = 4'd2;
            SEG_3:     bcd_out = 4'd3;
            SEG_4:     bcd_out = 4'd4;
            SEG_5:     bcd_out = 4'd5;
            SEG_6:     bcd_out = 4'd6;
            SEG_7:     bcd_out = 4'd7;
            SEG_8:     bcd_out = 4'd8;
            SEG_9:     bcd_out = 4'd9;
            SEG_BLANK: bcd_out = BCD_BLANK;
            default: begin
                bcd_out = BCD_ERR;
                err_out = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - samples a multiplexed 7-segment bus and publishes decoded BCD frames
module seg7_scan_decoder
    import seg7_scan_decoder_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    out_valid,
    output logic                    overflow
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [6:0]              seg_q, seg_d, prev_seg_q, prev_seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d, prev_an_q, prev_an_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
    logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    valid_q, valid_d;
    logic                    ovf_q, ovf_d;
    state_t                  state_q, state_d;

    logic [3:0]              dec_bcd;
    logic                    dec_err;
    logic                    one_hot;
    logic                    changed;
    logic                    accept;
    logic [NUM_DIGITS-1:0]   mask_set;
    logic                    publish;

    seg7_to_bcd u_seg7_to_bcd (
        .seg_in  (seg_q),
        .bcd_out (dec_bcd),
        .err_out (dec_err)
    );

    always_comb begin
        seg_d      = (SEG_ACTIVE_LOW != 0) ? ~seg_in : seg_in;
        an_d       = (SEG_ACTIVE_LOW != 0) ? ~an_in  : an_in;
        prev_seg_d = seg_q;
        prev_an_d  = an_q;
    end

    // Accept fires once per stable run; a saturated count only re-arms after a change.
    always_comb begin
        one_hot = $onehot(an_q);
        changed = ({seg_q, an_q} != {prev_seg_q, prev_an_q});
        if (!one_hot) begin
            cnt_d = '0;
        end else if (changed) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != STABLE_CNT) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        accept = one_hot && (cnt_d == STABLE_CNT) && (changed || (cnt_q != STABLE_CNT));
    end

    always_comb begin
        shadow_bcd_d = shadow_bcd_q;
        shadow_err_d = shadow_err_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (accept && an_q[i]) begin
                shadow_bcd_d[4*i +: 4] = dec_bcd;
                shadow_err_d[i]        = dec_err;
            end
        end
        mask_set = mask_q | (accept ? an_q : '0);
        mask_d   = publish ? '0 : mask_set;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (&mask_set) ? ST_PUBLISH : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (&mask_set) begin
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        publish = (state_q == ST_PUBLISH);
    end

    // A frame completing during the handshake cycle replaces the accepted one without a gap.
    always_comb begin
        bcd_d   = bcd_q;
        err_d   = err_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (publish) begin
            if (!valid_q || out_ready) begin
                bcd_d   = shadow_bcd_d;
                err_d   = shadow_err_d;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= '0;
            an_q         <= '0;
            prev_seg_q   <= '0;
            prev_an_q    <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            shadow_bcd_q <= '0;
            shadow_err_q <= '0;
            bcd_q        <= '0;
            err_q        <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            prev_seg_q   <= prev_seg_d;
            prev_an_q    <= prev_an_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_err_q <= shadow_err_d;
            bcd_q        <= bcd_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign digit_err = err_q;
    assign out_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed table-driven bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam logic [6:0] P0 = 7'h3F;
    localparam logic [6:0] P1 = 7'h06;
    localparam logic [6:0] P2 = 7'h5B;
    localparam logic [6:0] P3 = 7'h4F;
    localparam logic [6:0] P4 = 7'h66;
    localparam logic [6:0] P5 = 7'h6D;
    localparam logic [6:0] P6 = 7'h7D;
    localparam logic [6:0] P7 = 7'h07;
    localparam logic [6:0] P8 = 7'h7F;
    localparam logic [6:0] P9 = 7'h6F;
    localparam logic [6:0] PB = 7'h00;

    typedef struct {
        string       name;
        logic [27:0] segs;
        logic [15:0] bcd;
        logic [3:0]  err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic        out_ready;
    logic [15:0] bcd_out;
    logic [3:0]  digit_err;
    logic        out_valid;
    logic        overflow;

    int          total = 0;
    int          bad = 0;
    int          hi_cycles = 0;
    int          h0;
    logic [15:0] last_bcd = '0;
    logic [3:0]  last_err = '0;
    vec_t        vecs[7];

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .NUM_DIGITS     (4),
        .STABLE_CYCLES  (4),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .an_in     (an_in),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .digit_err (digit_err),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    always @(posedge clk) begin
        #1;
        if (out_valid) begin
            hi_cycles++;
            last_bcd = bcd_out;
            last_err = digit_err;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] s, input int hold);
        an_in  = an;
        seg_in = s;
        tick(hold);
    endtask

    task automatic scan(input logic [27:0] segs, input int hold);
        logic [3:0] an_v;
        for (int d = 3; d >= 0; d--) begin
            an_v    = '0;
            an_v[d] = 1'b1;
            drive(an_v, segs[7*d +: 7], hold);
        end
    endtask

    initial begin
        vecs[0] = '{"f1234", {P1, P2, P3, P4}, 16'h1234, 4'b0000};
        vecs[1] = '{"f5678", {P5, P6, P7, P8}, 16'h5678, 4'b0000};
        vecs[2] = '{"f9012", {P9, P0, P1, P2}, 16'h9012, 4'b0000};
        vecs[3] = '{"ferrblank", {P3, PB, 7'b1010101, P7}, 16'h3FE7, 4'b0010};
        vecs[4] = '{"fallerr", {7'h7E, 7'h01, 7'h3E, 7'h5C}, 16'hEEEE, 4'b1111};
        vecs[5] = '{"fblank", {PB, PB, PB, PB}, 16'hFFFF, 4'b0000};
        vecs[6] = '{"f4096", {P4, P0, P9, P6}, 16'h4096, 4'b0000};

        rst       = 1'b1;
        seg_in    = '0;
        an_in     = '0;
        out_ready = 1'b1;
        tick(3);
        check("rst_valid", out_valid, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_err", digit_err, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick(1);

        // Holds one cycle short of the stability threshold never accept
        scan({P1, P2, P3, P4}, 3);
        scan({P1, P2, P3, P4}, 3);
        drive(4'b0000, PB, 10);
        check("short_hold_no_frame", hi_cycles, 0);

        // Last digit held exactly STABLE_CYCLES: accept at edge 5, out_valid at edge 6
        drive(4'b1000, P1, 8);
        drive(4'b0100, P2, 8);
        drive(4'b0010, P3, 8);
        an_in  = 4'b0001;
        seg_in = P4;
        tick(4);
        an_in = 4'b0000;
        tick(1);
        check("lat_early", out_valid, 0);
        tick(1);
        check("lat_edge", out_valid, 1);
        check("lat_bcd", bcd_out, 16'h1234);
        tick(2);
        check("lat_pulse_len", hi_cycles, 1);

        for (int i = 0; i < 7; i++) begin
            h0 = hi_cycles;
            scan(vecs[i].segs, 8);
            tick(2);
            check({vecs[i].name, "_pulse"}, hi_cycles - h0, 1);
            check({vecs[i].name, "_bcd"}, last_bcd, vecs[i].bcd);
            check({vecs[i].name, "_err"}, last_err, vecs[i].err);
        end

        // Zero and multi-hot enables never qualify
        h0 = hi_cycles;
        drive(4'b0000, P1, 20);
        drive(4'b0110, P1, 20);
        check("bad_an_no_frame", hi_cycles - h0, 0);
        scan({P2, P4, P6, P8}, 8);
        tick(2);
        check("bad_an_resume_pulse", hi_cycles - h0, 1);
        check("bad_an_resume_bcd", last_bcd, 16'h2468);

        // Back-pressure: second frame dropped, overflow sticky
        out_ready = 1'b0;
        scan({P1, P2, P3, P4}, 8);
        check("bp_valid1", out_valid, 1);
        check("bp_bcd1", bcd_out, 16'h1234);
        check("bp_ovf1", overflow, 0);
        scan({P5, P6, P7, P8}, 8);
        check("bp_valid2", out_valid, 1);
        check("bp_bcd2", bcd_out, 16'h1234);
        check("bp_ovf2", overflow, 1);
        out_ready = 1'b1;
        tick(1);
        check("bp_drop", out_valid, 0);
        tick(3);
        check("bp_ovf_sticky", overflow, 1);
        check("bp_stays_low", out_valid, 0);

        // Reset mid-frame
        drive(4'b1000, P5, 8);
        drive(4'b0100, P5, 8);
        rst = 1'b1;
        tick(1);
        check("midrst_valid", out_valid, 0);
        check("midrst_bcd", bcd_out, 0);
        check("midrst_err", digit_err, 0);
        check("midrst_ovf", overflow, 0);
        tick(1);
        rst = 1'b0;
        h0  = hi_cycles;
        scan({P9, P8, P7, P6}, 8);
        tick(2);
        check("midrst_pulse", hi_cycles - h0, 1);
        check("midrst_frame", last_bcd, 16'h9876);
        check("midrst_frame_err", last_err, 0);
        check("midrst_ovf_after", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
